send_memory: RTL

//  Memory-dump UART transmitter: the read-back counterpart of the UART loader that fills IRAM.
//  On a start pulse it reads words first_addr..last_addr from a synchronous-read RAM port.

---
 rtl/send_memory.sv | 96 +++++++++
 1 files changed

// File: rtl/send_memory.sv
// send_memory: dumps RAM words first_addr..last_addr as two 8N1 UART frames each, high byte first
module send_memory #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 115200,
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] ram_ra,
   input  logic [DATA_W-1:0] ram_rd,
   output logic              tx,
   output logic              busy,
   output logic              done
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB);
   typedef enum logic [2:0] {IDLE, WAIT_RD, LATCH, SEND_HI, SEND_LO, NEXT, FIN} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cur_q, cur_d, end_q, end_d, ra_q, ra_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [3:0]        bit_q, bit_d;
   logic              tx_q, tx_d;
   logic              sending, bit_end, frame_end, data_bit;
   logic [7:0]        byte_v;
   logic [2:0]        idx;
   // tx is registered off the state, so the line lags the FSM by one cycle
   always_comb begin
      sending   = state_q == SEND_HI || state_q == SEND_LO;
      bit_end   = cnt_q == CW'(CPB - 1);
      frame_end = bit_end && bit_q == 4'd9;
      byte_v    = state_q == SEND_HI ? word_q[15:8] : word_q[7:0];
      idx       = 3'(bit_q - 4'd1);
      data_bit  = bit_q == 4'd0 ? 1'b0 : bit_q == 4'd9 ? 1'b1 : byte_v[idx];
      tx_d      = sending ? data_bit : 1'b1;
      cnt_d     = sending ? (bit_end ? '0 : cnt_q + 1'b1) : '0;
      bit_d     = sending && bit_end ? (bit_q == 4'd9 ? 4'd0 : bit_q + 4'd1) : bit_q;
      state_d   = state_q;
      cur_d     = cur_q;
      end_d     = end_q;
      ra_d      = ra_q;
      word_d    = word_q;
      unique case (state_q)
         IDLE: if (start) begin
            cur_d   = first_addr;
            end_d   = last_addr;
            ra_d    = first_addr;
            state_d = WAIT_RD;
         end
         WAIT_RD: state_d = LATCH;
         LATCH: begin
            word_d  = ram_rd;
            state_d = SEND_HI;
         end
         SEND_HI: state_d = frame_end ? SEND_LO : SEND_HI;
         SEND_LO: state_d = frame_end ? NEXT : SEND_LO;
         NEXT: if (cur_q == end_q) state_d = FIN;
         else begin
            cur_d   = cur_q + 1'b1;
            ra_d    = cur_q + 1'b1;
            state_d = WAIT_RD;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         end_q   <= '0;
         ra_q    <= '0;
         word_q  <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         end_q   <= end_d;
         ra_q    <= ra_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end
   assign ram_ra = ra_q;
   assign tx     = tx_q;
   assign busy   = state_q != IDLE;
   assign done   = state_q == FIN;
endmodule
